column_pipe_reg: RTL and testbench

Parametrised, flow-controlled register bank for column-organised board data. It generalises the fixed five-column, 25-bit capture register into a DEPTH-entry buffer of NUM_COLS × WIDTH words with a valid/ready handshake on both sides. It adds synchronous flush and in-place column rotation of the head entry. It sits between the column generator and the display/evaluation logic, decoupling producer and consumer stalls.

---
 rtl/column_pipe_reg.sv | 89 ++++++++
 tb/tb_column_pipe_reg.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/column_pipe_reg.sv
// rtl/column_pipe_reg.sv - flow-controlled DEPTH-entry column register bank; rotation built under COLUMN_PIPE_REG_ROTATE_EN
module column_pipe_reg #(
   parameter int WIDTH    = 25,
   parameter int NUM_COLS = 5,
   parameter int DEPTH    = 2
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         clear,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [NUM_COLS*WIDTH-1:0]    in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [NUM_COLS*WIDTH-1:0]    out_data,
   input  logic                         rot_en,
   input  logic                         rot_dir,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int TOT = NUM_COLS * WIDTH;
   localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW  = $clog2(DEPTH + 1);

   logic [TOT-1:0] mem [DEPTH];
   logic [PW-1:0]  rd_ptr, wr_ptr;
   logic [CW-1:0]  count;
   logic           push, pop, rotate;
   logic [TOT-1:0] head, head_rot;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   // Handshake flags come from the registered count only, so no input reaches an output combinationally.
   assign in_ready  = (count != CW'(DEPTH));
   assign out_valid = (count != '0);
   assign occupancy = count;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign head      = mem[rd_ptr];
   assign out_data  = out_valid ? head : '0;

`ifdef COLUMN_PIPE_REG_ROTATE_EN
   for (genvar k = 0; k < NUM_COLS; k++) begin : g_rot
      assign head_rot[k*WIDTH +: WIDTH] = rot_dir
         ? head[((k + NUM_COLS - 1) % NUM_COLS)*WIDTH +: WIDTH]
         : head[((k + 1) % NUM_COLS)*WIDTH +: WIDTH];
   end
   assign rotate = rot_en && out_valid && !pop && !clear;
`else
   logic unused_rot;
   assign unused_rot = rot_en ^ rot_dir;
   assign rotate     = 1'b0;
   assign head_rot   = head;
`endif

   // A rotate only happens with count in 1..DEPTH-1 or full without push, so head and tail writes never collide.
   always_ff @(posedge clock) begin
      if (!clear) begin
         if (push)
            mem[wr_ptr] <= in_data;
         if (rotate)
            mem[rd_ptr] <= head_rot;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= ptr_next(wr_ptr);
         if (pop)
            rd_ptr <= ptr_next(rd_ptr);
         if (push && !pop)
            count <= count + CW'(1);
         else if (pop && !push)
            count <= count - CW'(1);
      end
   end

endmodule

// File: tb/tb_column_pipe_reg.sv
// tb/tb_column_pipe_reg.sv - table and scoreboard bench for column_pipe_reg
module tb_column_pipe_reg;

   localparam int W   = 25;
   localparam int NC  = 5;
   localparam int D   = 2;
   localparam int TOT = W * NC;
   localparam int CW  = $clog2(D + 1);

   logic           clock = 1'b0;
   logic           reset_n, clear, in_valid, in_ready, out_valid, out_ready, rot_en, rot_dir;
   logic [TOT-1:0] in_data, out_data;
   logic [CW-1:0]  occupancy;

   int n_chk  = 0;
   int n_fail = 0;
   logic [TOT-1:0] q[$];

   column_pipe_reg #(.WIDTH(W), .NUM_COLS(NC), .DEPTH(D)) dut (
      .clock(clock), .reset_n(reset_n), .clear(clear),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .rot_en(rot_en), .rot_dir(rot_dir), .occupancy(occupancy)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic           iv;
      logic [TOT-1:0] data;
      logic           ordy;
      logic [CW-1:0]  exp_occ;
      logic           exp_irdy;
   } vec_t;

   function automatic logic [TOT-1:0] mk(input int c4, input int c3, input int c2, input int c1, input int c0);
      return {W'(c4), W'(c3), W'(c2), W'(c1), W'(c0)};
   endfunction

   function automatic logic [TOT-1:0] rot(input logic [TOT-1:0] d, input logic dir);
      logic [TOT-1:0] r;
      for (int k = 0; k < NC; k++) begin
         int s;
         s = dir ? (k + NC - 1) % NC : (k + 1) % NC;
         r[k*W +: W] = d[s*W +: W];
      end
      return r;
   endfunction

   task automatic chk(input string name, input logic [TOT-1:0] act, input logic [TOT-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic check_model();
      chk("in_ready", in_ready, q.size() != D);
      chk("out_valid", out_valid, q.size() != 0);
      chk("occupancy", occupancy, q.size());
      chk("out_data", out_data, (q.size() != 0) ? q[0] : '0);
   endtask

   // Called just after a falling edge: check current outputs, drive, update the scoreboard, advance one cycle.
   task automatic cycle(input logic iv, input logic [TOT-1:0] d, input logic ordy,
                        input logic re, input logic rd, input logic clr);
      logic do_push, do_pop;
      check_model();
      in_valid = iv; in_data = d; out_ready = ordy; rot_en = re; rot_dir = rd; clear = clr;
      do_push = iv && (q.size() != D);
      do_pop  = ordy && (q.size() != 0);
      if (clr) begin
         q.delete();
      end else begin
         if (do_pop)
            void'(q.pop_front());
`ifdef COLUMN_PIPE_REG_ROTATE_EN
         else if (re && q.size() != 0)
            q[0] = rot(q[0], rd);
`endif
         if (do_push)
            q.push_back(d);
      end
      @(posedge clock);
      @(negedge clock);
   endtask

   vec_t vecs[8];
   logic [TOT-1:0] a, b, e, h;

   initial begin
      reset_n = 1'b0; clear = 1'b0; in_valid = 1'b0; in_data = '0;
      out_ready = 1'b0; rot_en = 1'b0; rot_dir = 1'b0;
      repeat (2) @(negedge clock);
      chk("reset in_ready", in_ready, 1'b1);
      chk("reset out_valid", out_valid, 1'b0);
      chk("reset out_data", out_data, '0);
      chk("reset occupancy", occupancy, '0);
      reset_n = 1'b1;
      @(negedge clock);

      a = mk(32'h0A, 32'h0B, 32'h0C, 32'h0D, 32'h0E);
      b = mk(32'h1FFFFFF, 0, 32'h1555555, 32'h0AAAAAA, 32'h1234567);
      vecs[0] = '{1'b1, mk(5, 4, 3, 2, 1), 1'b0, CW'(1), 1'b1};
      vecs[1] = '{1'b0, '0,                1'b1, CW'(0), 1'b1};
      vecs[2] = '{1'b1, a,                 1'b0, CW'(1), 1'b1};
      vecs[3] = '{1'b1, b,                 1'b0, CW'(2), 1'b0};
      vecs[4] = '{1'b1, mk(9, 9, 9, 9, 9), 1'b0, CW'(2), 1'b0};
      vecs[5] = '{1'b0, '0,                1'b1, CW'(1), 1'b1};
      vecs[6] = '{1'b0, '0,                1'b1, CW'(0), 1'b1};
      vecs[7] = '{1'b0, '0,                1'b0, CW'(0), 1'b1};
      for (int i = 0; i < 8; i++) begin
         cycle(vecs[i].iv, vecs[i].data, vecs[i].ordy, 1'b0, 1'b0, 1'b0);
         chk($sformatf("vec%0d occupancy", i), occupancy, vecs[i].exp_occ);
         chk($sformatf("vec%0d in_ready", i), in_ready, vecs[i].exp_irdy);
         if (i == 0)
            chk("first push col0", out_data[W-1:0], W'(1));
      end

      // Streaming: one entry per cycle, occupancy pinned at 1 after the first push.
      for (int i = 0; i < 10; i++) begin
         cycle(1'b1, {$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 1'b0, 1'b0);
         chk($sformatf("stream%0d occupancy", i), occupancy, CW'(1));
      end
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      chk("stream drained", occupancy, CW'(0));

      h = mk(5, 4, 3, 2, 1);
      e = mk(32'h11, 32'h22, 32'h33, 32'h44, 32'h55);
      cycle(1'b1, h, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, e, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
`ifdef COLUMN_PIPE_REG_ROTATE_EN
      chk("rotate left", out_data, mk(1, 5, 4, 3, 2));
`else
      chk("rotate left ignored", out_data, h);
`endif
      cycle(1'b0, '0, 1'b0, 1'b1, 1'b1, 1'b0);
      chk("rotate right back", out_data, h);
      cycle(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0);
      chk("rotate with pop", out_data, e);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);

      cycle(1'b1, a, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, e, 1'b0, 1'b1, 1'b0, 1'b1);
      chk("clear occupancy", occupancy, CW'(0));
      chk("clear out_valid", out_valid, 1'b0);
      cycle(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);

      // Asynchronous reset between edges with the bank full.
      cycle(1'b1, a, 1'b0, 1'b0, 1'b0, 1'b0);
      cycle(1'b1, b, 1'b0, 1'b0, 1'b0, 1'b0);
      check_model();
      in_valid = 1'b0;
      #2 reset_n = 1'b0;
      #1;
      q.delete();
      chk("async rst in_ready", in_ready, 1'b1);
      chk("async rst out_valid", out_valid, 1'b0);
      chk("async rst occupancy", occupancy, '0);
      chk("async rst out_data", out_data, '0);
      @(negedge clock);
      reset_n = 1'b1;
      cycle(1'b1, e, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("post reset push", out_data, e);
      cycle(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0);
      check_model();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
